apb_master_arbiter: RTL
=======================

# apb_master_arbiter

Two-port APB master that shares the single APB memory slave between the RISC-V core's data port (requester 0) and instruction-fetch port (requester 1). It arbitrates round-robin, runs one APB3 SETUP/ACCESS transfer at a time, and returns read data or write completion to the winner. A wait-state watchdog aborts transfers on which `pready` never arrives.

## Interface

**Parameters**
- `DATA_LENGTH`, 32, width of write data and read data.
- `ADDRESS_LENGTH`, 32, width of addresses.
- `TIMEOUT_CYCLES`, 16, maximum number of ACCESS cycles before abort. Must be at least 2.

**Ports**
- `from_top_clk` in 1: the single clock. All logic is sampled on its rising edge.
- `preset_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 2: per-requester request; bit n belongs to requester n.
- `req_write` in 2: per-requester direction; 1 = write.
- `req0_addr`, `req1_addr` in ADDRESS_LENGTH: request addresses.
- `req0_wdata`, `req1_wdata` in DATA_LENGTH: request write data.
- `req_ready` out 2: accept strobe, one-hot or zero. Combinational.
- `rsp_done` out 2: completion pulse, one-hot or zero. Registered.
- `rsp_err` out 1: qualifies `rsp_done`; 1 = timeout abort.
- `rsp_rdata` out DATA_LENGTH: read data; valid while `rsp_done` is nonzero.
- `psel`, `penable`, `pwrite` out 1: APB master controls.
- `paddr` out ADDRESS_LENGTH: APB address.
- `pwdata` out DATA_LENGTH: APB write data.
- `pready` in 1: slave ready.
- `prdata` in DATA_LENGTH: slave read data.

## Operation

**FSM states:** IDLE, SETUP, ACCESS.

**IDLE**
- If any `req_valid` bit is set, pick the winner and assert that requester's `req_ready` bit combinationally.
- Winner selection when both are valid: the requester not granted last time. With only one valid, it wins.
- On the accepting edge:
  - latch the winner's address, write data and `req_write` bit into `paddr`/`pwdata`/`pwrite`;
  - store the winner index;
  - update the round-robin pointer;
  - go to SETUP.

**SETUP**
- `psel`=1, `penable`=0.
- Move to ACCESS unconditionally and clear the wait counter.

**ACCESS**
- `psel`=1, `penable`=1.
- If `pready`=1:
  - for reads, register `prdata` into `rsp_rdata`; for writes, `rsp_rdata` is 0;
  - pulse `rsp_done[winner]` with `rsp_err`=0;
  - go to IDLE.
- Else, if the wait counter equals `TIMEOUT_CYCLES`-1:
  - pulse `rsp_done[winner]` with `rsp_err`=1 and `rsp_rdata`=0;
  - go to IDLE.
- Else increment the wait counter.
- `pready` takes precedence over timeout in the same cycle.

**General rules**
- `paddr`, `pwrite` and `pwdata` are held stable from SETUP through the end of ACCESS.
- In IDLE, `psel`=0 and `penable`=0. Address and data hold their last values.
- `req_ready` is 0 in every state other than IDLE.
- Requesters must hold valid, address and data until they see `req_ready`. A request that drops before being accepted is ignored.
- The wait counter is $clog2(TIMEOUT_CYCLES) bits and never wraps.

## Timing

**Reset values:** all outputs are 0, including `rsp_rdata`. State = IDLE. Round-robin pointer favours requester 0 first.

**Latency for a zero-wait transfer**
- Request accepted at edge E0.
- SETUP during the cycle following E0.
- ACCESS during the cycle following E1, with `pready` sampled at E2.
- `rsp_done` is high during the cycle following E2, the same cycle the FSM is back in IDLE.
- A new request may therefore be accepted at E3: 3 cycles per transfer, 1 idle cycle between back-to-back transfers.

**Wait states:** each cycle of `pready`=0 in ACCESS adds one cycle of latency.

**Timeout:** with `pready` held low, `rsp_done`/`rsp_err` assert in the cycle after the TIMEOUT_CYCLES-th ACCESS cycle.

**Boundary cases**
- Reset asserted mid-transfer: immediate return to IDLE, `psel`/`penable` drop asynchronously, no `rsp_done` is issued, and the pointer is reset.
- Simultaneous request and completion: not possible, because acceptance happens only in IDLE.
- `rsp_done` is exactly one cycle wide.

## Structure

- Package `apb_arb_pkg` holds:
  - the state enum `apb_arb_state_t` (IDLE/SETUP/ACCESS);
  - constants `REQ_DATA`=0 and `REQ_FETCH`=1;
  - the APB direction constants `APB_READ`/`APB_WRITE`.
- One sub-module, `apb_rr_pick`, is natural:
  - it takes the 2-bit valid vector and the last-grant pointer;
  - it returns a one-hot grant and is purely combinational.
- The top-level holds the FSM, the latches, the wait counter and the response registers.

## Test plan

- **Single read, zero wait:** reset, then `req_valid`=01 with addr 0x0000_0040 read, slave `pready`=1 and `prdata`=0xDEAD_BEEF.
  - Expected: `req_ready`=01 at E0, `psel` high from E0 to E2, `penable` high only in ACCESS, `rsp_done`=01 with `rsp_rdata`=0xDEAD_BEEF in the cycle after E2, `rsp_err`=0.
- **Write with wait states:** requester 1 writes 0x1234_5678 to 0x100; slave holds `pready` low for 3 ACCESS cycles.
  - Expected: `paddr`/`pwdata` stable throughout, `rsp_done`=10 six cycles after acceptance, `rsp_rdata`=0.
- **Contention:** both requesters held valid continuously for 4 transfers.
  - Expected: grant order 0,1,0,1, and each `req_ready` is one cycle wide.
- **Timeout:** `TIMEOUT_CYCLES`=16 and `pready` tied low.
  - Expected: 16 ACCESS cycles, then `rsp_done` for the winner with `rsp_err`=1 and `rsp_rdata`=0, FSM back in IDLE, and the next request serviced normally.
- **Reset mid-ACCESS:** deassert `preset_n` during a wait state.
  - Expected: `psel`/`penable` go to 0 without a clock edge, no `rsp_done` is issued, and after reset requester 0 is granted first.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_arb_state_t;

    localparam int unsigned REQ_DATA  = 0;
    localparam int unsigned REQ_FETCH = 1;

    localparam logic APB_READ  = 1'b0;
    localparam logic APB_WRITE = 1'b1;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin picker: one-hot grant, favouring the requester not granted last time.
module apb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == 1'(REQ_FETCH)) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3 master shared by the data port (requester 0) and fetch port (requester 1),
// one SETUP/ACCESS transfer at a time, with a wait-state watchdog.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned DATA_LENGTH    = 32,
    parameter int unsigned ADDRESS_LENGTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      from_top_clk,
    input  logic                      preset_n,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [ADDRESS_LENGTH-1:0] req0_addr,
    input  logic [ADDRESS_LENGTH-1:0] req1_addr,
    input  logic [DATA_LENGTH-1:0]    req0_wdata,
    input  logic [DATA_LENGTH-1:0]    req1_wdata,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_done,
    output logic                      rsp_err,
    output logic [DATA_LENGTH-1:0]    rsp_rdata,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDRESS_LENGTH-1:0] paddr,
    output logic [DATA_LENGTH-1:0]    pwdata,
    input  logic                      pready,
    input  logic [DATA_LENGTH-1:0]    prdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    apb_arb_state_t  state_q, state_d;
    logic            last_grant_q;
    logic            winner_q;
    logic [CntW-1:0] wait_cnt_q;
    logic [1:0]      grant;
    logic            accept;
    logic            win_idx;
    logic            done_ok;
    logic            done_timeout;

    apb_rr_pick u_rr_pick (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept       = (state_q == StIdle) && (grant != 2'b00);
    assign win_idx      = grant[1];
    assign done_ok      = (state_q == StAccess) && pready;
    assign done_timeout = (state_q == StAccess) && !pready && (wait_cnt_q == CntMax);

    always_ff @(posedge from_top_clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (done_ok || done_timeout) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Bus strobes decode straight from state so reset drops them without a clock edge.
    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        req_ready = 2'b00;
        unique case (state_q)
            StIdle:   req_ready = grant;
            StSetup:  psel = 1'b1;
            StAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge from_top_clk or negedge preset_n) begin
        if (!preset_n) begin
            paddr        <= '0;
            pwdata       <= '0;
            pwrite       <= APB_READ;
            winner_q     <= 1'b0;
            last_grant_q <= 1'(REQ_FETCH);
            wait_cnt_q   <= '0;
            rsp_done     <= 2'b00;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            rsp_done <= 2'b00;
            rsp_err  <= 1'b0;
            if (accept) begin
                paddr        <= win_idx ? req1_addr : req0_addr;
                pwdata       <= win_idx ? req1_wdata : req0_wdata;
                pwrite       <= req_write[win_idx];
                winner_q     <= win_idx;
                last_grant_q <= win_idx;
            end
            if (state_q == StSetup) begin
                wait_cnt_q <= '0;
            end
            if (done_ok) begin
                rsp_done  <= winner_q ? 2'b10 : 2'b01;
                rsp_rdata <= (pwrite == APB_WRITE) ? '0 : prdata;
            end else if (done_timeout) begin
                rsp_done  <= winner_q ? 2'b10 : 2'b01;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (state_q == StAccess) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

endmodule
